// File: rtl/gth_prbs_chk.sv
// PRBS31 receive checker for the SFP0 GTH link: self-synchronising lock, free-running compare, saturating error counters.
// Optional bit-error counting is built only when GTH_PRBS_BITERR_EN is defined; otherwise bit_err_cnt is tied to zero.
module gth_prbs_chk #(
    parameter int DATA_W      = 32,
    parameter int LOCK_CNT    = 64,
    parameter int UNLOCK_ERRS = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_vld,
    input  logic              clr_cnt,
    output logic              locked,
    output logic [CNT_W-1:0]  word_err_cnt,
    output logic [CNT_W-1:0]  bit_err_cnt,
    output logic [3:0]        status
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    // Bits 28..30 and 31 depend on bits of the word being built, so order matters.
    function automatic logic [31:0] prbsNext(input logic [31:0] p);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 28; i++) n[i] = p[i+1] ^ p[i+4];
        for (int i = 28; i < 31; i++) n[i] = p[i+1] ^ n[i-28];
        n[31] = n[0] ^ n[3];
        return n;
    endfunction

`ifdef GTH_PRBS_BITERR_EN
    function automatic logic [5:0] popCount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
        return n;
    endfunction
`endif

    state_t              state_q;
    logic                s1Vld_q;
    logic [DATA_W-1:0]   s1Data_q;
    logic [DATA_W-1:0]   prev_q;
    logic                havePrev_q;
    logic [DATA_W-1:0]   pred_q;
    logic [GOOD_W-1:0]   good_q;
    logic [BAD_W-1:0]    bad_q;
    logic [CNT_W-1:0]    wordErr_q, wordErr_d;
    logic [CNT_W-1:0]    bitErr_q, bitErr_d;
    logic                sticky_q, sticky_d;
    logic                sat_q, sat_d;
    logic [DATA_W-1:0]   expected;
    logic                mismatch;
    logic                errWord;

`ifdef GTH_PRBS_BITERR_EN
    logic [5:0]          diffBits;
    logic [CNT_W:0]      bitSum;
`endif

    always_comb begin
        expected  = (state_q == LOCKED) ? prbsNext(pred_q) : prbsNext(prev_q);
        mismatch  = (s1Data_q != expected);
        errWord   = s1Vld_q && (state_q == LOCKED) && mismatch;

        wordErr_d = wordErr_q;
        if (errWord && (wordErr_q != '1)) wordErr_d = wordErr_q + 1'b1;

`ifdef GTH_PRBS_BITERR_EN
        diffBits  = popCount32(s1Data_q ^ expected);
        bitSum    = {1'b0, bitErr_q} + (CNT_W+1)'(diffBits);
        bitErr_d  = bitErr_q;
        if (errWord) bitErr_d = bitSum[CNT_W] ? '1 : bitSum[CNT_W-1:0];
`else
        bitErr_d  = '0;
`endif

        sticky_d  = sticky_q | errWord;
        sat_d     = sat_q | (wordErr_d == '1) | (bitErr_d == '1);

        // A clear wins over an error landing on the same edge.
        if (clr_cnt) begin
            wordErr_d = '0;
            bitErr_d  = '0;
            sticky_d  = 1'b0;
            sat_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEARCH;
            s1Vld_q    <= 1'b0;
            s1Data_q   <= '0;
            prev_q     <= '0;
            havePrev_q <= 1'b0;
            pred_q     <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            wordErr_q  <= '0;
            bitErr_q   <= '0;
            sticky_q   <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            s1Vld_q   <= rx_vld;
            if (rx_vld) s1Data_q <= rx_data;
            wordErr_q <= wordErr_d;
            bitErr_q  <= bitErr_d;
            sticky_q  <= sticky_d;
            sat_q     <= sat_d;

            if (s1Vld_q) begin
                case (state_q)
                    SEARCH: begin
                        prev_q     <= s1Data_q;
                        havePrev_q <= 1'b1;
                        if (havePrev_q) begin
                            if (mismatch) begin
                                good_q <= '0;
                            end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                                state_q <= LOCKED;
                                pred_q  <= s1Data_q;
                                bad_q   <= '0;
                                good_q  <= '0;
                            end else begin
                                good_q <= good_q + 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        // Predictor free-runs so one corrupted word costs exactly one word error.
                        pred_q <= expected;
                        if (!mismatch) begin
                            bad_q <= '0;
                        end else if (bad_q == BAD_W'(UNLOCK_ERRS - 1)) begin
                            state_q    <= SEARCH;
                            good_q     <= '0;
                            bad_q      <= '0;
                            havePrev_q <= 1'b0;
                        end else begin
                            bad_q <= bad_q + 1'b1;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign locked       = (state_q == LOCKED);
    assign word_err_cnt = wordErr_q;
    assign bit_err_cnt  = bitErr_q;
    assign status       = {sat_q, sticky_q, locked, ~locked};

endmodule
